// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch unit.
package if_prefetch_pkg;

  localparam int unsigned INST_ADDR_W_DEF = 32;
  localparam int unsigned INST_W_DEF      = 32;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF     = 32'd4;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// Synchronous FIFO with clear; push while full is accepted when a pop happens in the same cycle.
module if_prefetch_sync_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; only the pointers and count define what is valid,
  // so resetting the array would cost flops for no behavioural benefit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch unit: credit-limited sequential fetch into a prefetch queue
// presented to decode under valid/ready, with redirect that discards stale work.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = INST_ADDR_W_DEF,
  parameter int unsigned        INST_W   = INST_W_DEF,
  parameter int unsigned        DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(PC_STEP_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [ADDR_W-1:0]       flush_pc_i,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [INST_W-1:0]       mem_rdata_i,
  output logic                    inst_valid_o,
  output logic [ADDR_W-1:0]       inst_pc_o,
  output logic [INST_W-1:0]       inst_o,
  input  logic                    inst_ready_i,
  output logic [cnt_w(DEPTH)-1:0] occupancy_o
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned Q_W   = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W:0]    credits_used;
  logic              grant;
  logic              accept;
  logic              deliver;

  logic [ADDR_W-1:0] tag_pc;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_full;
  logic              tag_empty;

  logic [Q_W-1:0]    q_rdata;
  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              q_empty;
  logic              unused_status;

  assign credits_used = {1'b0, q_count} + {1'b0, outstanding};
  assign mem_req_o    = !rst && !flush_i && (credits_used < (CNT_W+1)'(DEPTH));
  assign mem_addr_o   = fetch_pc;
  assign grant        = mem_req_o && mem_gnt_i;

  // A word is kept only if it answers a live request; stale ones were untagged at flush.
  assign accept  = mem_rvalid_i && !flush_i && (discard == '0) && !tag_empty;
  assign deliver = inst_valid_o && inst_ready_i && !flush_i;

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no path can leave a value held and infer a latch.
  always_comb begin
    outstanding_next = outstanding;
    case ({grant, mem_rvalid_i})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (flush_i) begin
        fetch_pc <= flush_pc_i;
        discard  <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_STEP;
        if (mem_rvalid_i && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  if_prefetch_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (accept),
    .clear (flush_i),
    .wdata (fetch_pc),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  if_prefetch_sync_fifo #(.WIDTH(Q_W), .DEPTH(DEPTH)) u_inst_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (deliver),
    .clear (flush_i),
    .wdata ({tag_pc, mem_rdata_i}),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign unused_status = ^{tag_count, tag_full, q_full};

  // Head fields are masked so decode sees zeros whenever nothing is valid.
  assign inst_valid_o = !q_empty;
  assign inst_pc_o    = inst_valid_o ? q_rdata[INST_W +: ADDR_W] : '0;
  assign inst_o       = inst_valid_o ? q_rdata[INST_W-1:0]       : '0;
  assign occupancy_o  = q_count;

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench: in-order variable-latency memory plus a queue-level model of
// the delivered instruction stream, credit limit, and redirect behaviour.
module tb_if_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_o;
  logic        inst_ready_i;
  logic [2:0]  occupancy_o;

  always #5 clk = ~clk;

  if_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_valid_o (inst_valid_o),
    .inst_pc_o    (inst_pc_o),
    .inst_o       (inst_o),
    .inst_ready_i (inst_ready_i),
    .occupancy_o  (occupancy_o)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  req_t        inflight[$];  // requests granted by memory, in order
  logic [31:0] exp_q[$];     // words that decode should see, in order
  logic [31:0] issue_pc;     // next address the fetch stream should request
  int          cyc;
  int          total = 0;
  int          bad = 0;
  int          p_gnt, p_rv, p_rdy, p_flush, lat_min, lat_max;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] image(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic model_reset();
    inflight.delete();
    exp_q.delete();
    issue_pc = 32'h0;
    cyc      = 0;
  endtask

  task automatic set_mode(input int g, input int rv, input int rdy, input int fl,
                          input int lmin, input int lmax);
    p_gnt = g; p_rv = rv; p_rdy = rdy; p_flush = fl; lat_min = lmin; lat_max = lmax;
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model to the next edge.
  task automatic step(input bit force_flush, input logic [31:0] fpc);
    req_t r;
    @(negedge clk);
    cyc++;
    rst          = 1'b0;
    flush_i      = force_flush || roll(p_flush);
    flush_pc_i   = force_flush ? fpc : ($urandom() & 32'hFFFF_FFFC);
    inst_ready_i = roll(p_rdy);
    mem_gnt_i    = roll(p_gnt);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom();
    if (inflight.size() > 0) begin
      if (inflight[0].due <= cyc && roll(p_rv)) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = image(inflight[0].addr);
      end
    end
    #1;
    check("occupancy", occupancy_o, exp_q.size());
    check("inst_valid", inst_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("inst_pc", inst_pc_o, exp_q[0]);
      check("inst", inst_o, image(exp_q[0]));
    end
    check("mem_req", mem_req_o, !flush_i && (exp_q.size() + inflight.size() < DEPTH));
    if (mem_req_o) check("mem_addr", mem_addr_o, issue_pc);
    check("inflight_bound", inflight.size() <= DEPTH, 1);

    if (exp_q.size() != 0 && inst_ready_i && !flush_i) void'(exp_q.pop_front());
    if (mem_rvalid_i) begin
      r = inflight.pop_front();
      if (!r.stale && !flush_i) exp_q.push_back(r.addr);
    end
    if (flush_i) begin
      exp_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      issue_pc = flush_pc_i;
    end
    if (mem_req_o && mem_gnt_i) begin
      inflight.push_back('{mem_addr_o, 1'b0, cyc + $urandom_range(lat_max, lat_min)});
      issue_pc += 32'd4;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_pc", inst_pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    check("rst_occ", occupancy_o, 0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // Zero-wait memory, decode always ready: one instruction per cycle from cycle 3.
    set_mode(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0);
      if (cyc >= 3) begin
        check("zw_valid", inst_valid_o, 1);
        check("zw_pc", inst_pc_o, 32'((cyc - 3) * 4));
      end
    end

    // Decode stalls: queue fills to DEPTH and fetch stops.
    set_mode(100, 100, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    check("stall_occ", occupancy_o, DEPTH);
    check("stall_req", mem_req_o, 0);
    set_mode(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0);

    // Three-cycle memory, then redirect to 0x100 with requests in flight.
    set_mode(100, 100, 100, 0, 3, 3);
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    check("inflight_at_flush", inflight.size() >= 2, 1);
    step(1'b1, 32'h100);
    begin
      int n = 0;
      while (n < 20) begin
        step(1'b0, '0);
        n++;
        if (inst_valid_o) break;
      end
    end
    check("flush_target", inst_pc_o, 32'h100);

    // Address wrap past the top of the space.
    set_mode(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    step(1'b1, 32'hFFFF_FFF8);
    step(1'b0, '0);
    check("wrap_a", mem_addr_o, 32'hFFFF_FFF8);
    step(1'b0, '0);
    check("wrap_b", mem_addr_o, 32'hFFFF_FFFC);
    step(1'b0, '0);
    check("wrap_c", mem_addr_o, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step(1'b0, '0);

    // Random traffic with redirects and variable latency.
    set_mode(70, 70, 60, 4, 1, 4);
    for (int i = 0; i < 3000; i++) step(1'b0, '0);

    // Reset asserted mid-stream.
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    check("midrst_req_now", mem_req_o, 0);
    @(posedge clk);
    #1;
    check_reset_outputs();
    model_reset();

    set_mode(60, 80, 70, 3, 1, 3);
    for (int i = 0; i < 1500; i++) step(1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
